// File: rtl/cpu_boot_sequencer_pkg.sv
// Boot sequencer shared types and defaults.
// State encoding and default widths.
package cpu_boot_sequencer_pkg;

  localparam int DATA_W_D   = 32;
  localparam int ADDR_W_D   = 8;
  localparam int NUM_REGS_D = 32;
  localparam int REG_AW_D   = 5;
  localparam int CNT_W_D    = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REG_INIT,
    ST_LOAD,
    ST_RUN,
    ST_DONE
  } boot_st_t;

endpackage

// File: rtl/boot_run_monitor.sv
// Boot sequencer RUN supervisor.
// Counts run cycles, checks budget, arbitrates halt.
module boot_run_monitor
  import cpu_boot_sequencer_pkg::*;
#(
  parameter int CNT_W = CNT_W_D
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic [CNT_W-1:0] budget_in,
  input  logic             run,
  input  logic             halt,
  output logic [CNT_W-1:0] cycles_run,
  output logic             timed_out,
  output logic             finish
);

  logic [CNT_W-1:0] budget;
  logic [CNT_W:0]   cnt_inc;
  logic             sat;
  logic             expire;

  assign cnt_inc = {1'b0, cycles_run} + (CNT_W+1)'(1);
  assign sat     = &cycles_run;
  assign expire  = (budget != '0) &&
                   (cnt_inc == {1'b0, budget});
  assign finish  = run && (halt || expire);

  // Budget latch, saturating run counter, expiry flag
  always_ff @(posedge clock) begin
    if (reset) begin
      budget     <= '0;
      cycles_run <= '0;
      timed_out  <= 1'b0;
    end else if (clear) begin
      budget     <= budget_in;
      cycles_run <= '0;
      timed_out  <= 1'b0;
    end else if (run) begin
      if (!sat)
        cycles_run <= cnt_inc[CNT_W-1:0];
      if (expire && !halt)
        timed_out <= 1'b1;
    end
  end

endmodule

// File: rtl/cpu_boot_sequencer.sv
// CPU bring-up sequencer: reg init, image load,
// supervised run.
module cpu_boot_sequencer
  import cpu_boot_sequencer_pkg::*;
#(
  parameter int DATA_W   = DATA_W_D,
  parameter int ADDR_W   = ADDR_W_D,
  parameter int NUM_REGS = NUM_REGS_D,
  parameter int REG_AW   = REG_AW_D,
  parameter int CNT_W    = CNT_W_D
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   load_len,
  input  logic [CNT_W-1:0]  run_cycles,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              reg_we,
  output logic [REG_AW-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              cpu_reset,
  input  logic              halt,
  output logic              busy,
  output logic              done,
  output logic              timed_out,
  output logic [CNT_W-1:0]  cycles_run
);

  localparam int LW    = ADDR_W + 1;
  localparam int DEPTH = 2 ** ADDR_W;

  localparam logic [LW-1:0] DEPTH_L =
    LW'(DEPTH);
  localparam logic [REG_AW-1:0] LAST_REG =
    REG_AW'(NUM_REGS - 1);

  boot_st_t state;
  boot_st_t state_nx;

  logic [LW-1:0] len;
  logic [LW-1:0] idx;

  logic start_ok;
  logic accept;
  logic reg_last;
  logic load_last;
  logic in_run;
  logic run_fin;

  logic              reg_we_d;
  logic [REG_AW-1:0] reg_addr_d;
  logic [DATA_W-1:0] reg_wdata_d;
  logic              mem_we_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_d;
  logic              busy_d;
  logic              done_d;
  logic              cpu_reset_d;

  assign start_ok = start &&
    (state == ST_IDLE || state == ST_DONE);
  assign load_ready = (state == ST_LOAD);
  assign accept     = load_ready && load_valid;
  assign reg_last   = (reg_addr == LAST_REG);
  assign load_last  = (idx + LW'(1) == len);
  assign in_run     = (state == ST_RUN);

  boot_run_monitor #(
    .CNT_W (CNT_W)
  ) u_run_mon (
    .clock      (clock),
    .reset      (reset),
    .clear      (start_ok),
    .budget_in  (run_cycles),
    .run        (in_run),
    .halt       (halt),
    .cycles_run (cycles_run),
    .timed_out  (timed_out),
    .finish     (run_fin)
  );

  // State register
  always_ff @(posedge clock) begin
    if (reset)
      state <= ST_IDLE;
    else
      state <= state_nx;
  end

  // Next-state decode
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE, ST_DONE:
        if (start)
          state_nx = ST_REG_INIT;
      ST_REG_INIT:
        if (reg_last)
          state_nx = (len == '0) ? ST_RUN
                                 : ST_LOAD;
      ST_LOAD:
        if (accept && load_last)
          state_nx = ST_RUN;
      ST_RUN:
        if (run_fin)
          state_nx = ST_DONE;
      default:
        state_nx = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    reg_addr_d = reg_addr;
    unique case (1'b1)
      start_ok:
        reg_addr_d = '0;
      (state == ST_REG_INIT) && !reg_last:
        reg_addr_d = reg_addr + REG_AW'(1);
      default:
        reg_addr_d = reg_addr;
    endcase
    reg_we_d    = (state_nx == ST_REG_INIT);
    reg_wdata_d = DATA_W'(reg_addr_d);
    mem_we_d    = accept;
    mem_addr_d  = accept ? idx[ADDR_W-1:0]
                         : mem_addr;
    mem_wdata_d = accept ? load_data
                         : mem_wdata;
    busy_d      = (state_nx == ST_REG_INIT) ||
                  (state_nx == ST_LOAD) ||
                  (state_nx == ST_RUN);
    done_d      = (state_nx == ST_DONE);
    cpu_reset_d = (state_nx != ST_RUN);
  end

  // Output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      reg_we    <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cpu_reset <= 1'b1;
    end else begin
      reg_we    <= reg_we_d;
      reg_addr  <= reg_addr_d;
      reg_wdata <= reg_wdata_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      busy      <= busy_d;
      done      <= done_d;
      cpu_reset <= cpu_reset_d;
    end
  end

  // Load length latch (clamped) and word index
  always_ff @(posedge clock) begin
    if (reset) begin
      len <= '0;
      idx <= '0;
    end else if (start_ok) begin
      len <= (load_len > DEPTH_L) ? DEPTH_L
                                  : load_len;
      idx <= '0;
    end else if (accept) begin
      idx <= idx + LW'(1);
    end
  end

endmodule
